// File: rtl/traffic_ctrl_n.sv
// N-approach round-robin traffic-light controller with internal phase timers.
// Optional emergency preemption is compiled in with `define TRAFFIC_PREEMPT_EN.
module traffic_ctrl_n #(
  parameter int unsigned NUM_DIR  = 2,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned INIT_CLR = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [CNT_W-1:0]             g_time,
  input  logic [CNT_W-1:0]             y_time,
  input  logic [CNT_W-1:0]             r_time,
`ifdef TRAFFIC_PREEMPT_EN
  input  logic                         preempt_req,
  input  logic [$clog2(NUM_DIR)-1:0]   preempt_dir,
  output logic                         preempt_active,
`endif
  output logic [3*NUM_DIR-1:0]         lamps,
  output logic [$clog2(NUM_DIR)-1:0]   active_dir,
  output logic                         phase_g,
  output logic                         phase_y,
  output logic                         phase_r,
  output logic                         phase_end,
  output logic [CNT_W-1:0]             timer
);

  localparam int unsigned DIR_W = $clog2(NUM_DIR);
  localparam logic [DIR_W-1:0] LAST_DIR = DIR_W'(NUM_DIR - 1);

  typedef enum logic [1:0] {
    StGreen  = 2'b00,
    StYellow = 2'b01,
    StAllRed = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [DIR_W-1:0] dir_q, dir_d;
  logic [DIR_W-1:0] dir_inc, green_dir;
  logic             preempt_cut, preempt_hold;

  // A zero duration still yields a one-cycle phase.
  function automatic logic [CNT_W-1:0] load_val(input logic [CNT_W-1:0] dur);
    return (dur == '0) ? '0 : dur - CNT_W'(1);
  endfunction

  assign dir_inc = (dir_q == LAST_DIR) ? '0 : dir_q + DIR_W'(1);

`ifdef TRAFFIC_PREEMPT_EN
  assign preempt_active = preempt_req && (32'(preempt_dir) < NUM_DIR);
  assign preempt_cut    = preempt_active && (dir_q != preempt_dir);
  assign preempt_hold   = preempt_active && (dir_q == preempt_dir);
  assign green_dir      = preempt_active ? preempt_dir : dir_inc;
`else
  assign preempt_cut    = 1'b0;
  assign preempt_hold   = 1'b0;
  assign green_dir      = dir_inc;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StAllRed;
      timer_q <= CNT_W'(INIT_CLR - 1);
      dir_q   <= LAST_DIR;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    dir_d     = dir_q;
    phase_end = 1'b0;
    case (state_q)
      StGreen: begin
        if (en) begin
          if (preempt_cut || ((timer_q == '0) && !preempt_hold)) begin
            phase_end = 1'b1;
            state_d   = StYellow;
            timer_d   = load_val(y_time);
          end else if (!preempt_hold) begin
            timer_d = timer_q - CNT_W'(1);
          end
        end
      end
      StYellow: begin
        if (en) begin
          if (timer_q == '0) begin
            phase_end = 1'b1;
            state_d   = StAllRed;
            timer_d   = load_val(r_time);
          end else begin
            timer_d = timer_q - CNT_W'(1);
          end
        end
      end
      StAllRed: begin
        if (en) begin
          if (timer_q == '0) begin
            phase_end = 1'b1;
            state_d   = StGreen;
            timer_d   = load_val(g_time);
            dir_d     = green_dir;
          end else begin
            timer_d = timer_q - CNT_W'(1);
          end
        end
      end
      // Unreachable encoding: fall back to a one-cycle clearance.
      default: begin
        state_d = StAllRed;
        timer_d = '0;
      end
    endcase
  end

  always_comb begin
    lamps = {NUM_DIR{3'b001}};
    for (int d = 0; d < NUM_DIR; d++) begin
      if (DIR_W'(d) == dir_q) begin
        if (state_q == StGreen) begin
          lamps[3*d +: 3] = 3'b100;
        end else if (state_q == StYellow) begin
          lamps[3*d +: 3] = 3'b010;
        end
      end
    end
  end

  assign active_dir = dir_q;
  assign phase_g    = (state_q == StGreen);
  assign phase_y    = (state_q == StYellow);
  assign phase_r    = (state_q == StAllRed);
  assign timer      = timer_q;

endmodule

// File: tb/tb_traffic_ctrl_n.sv
// Scoreboard bench for traffic_ctrl_n (NUM_DIR=3) against an elapsed-count reference model.
// Define TRAFFIC_PREEMPT_EN to also exercise the preemption ports.
module tb_traffic_ctrl_n;
  localparam int NumDir  = 3;
  localparam int CntW    = 16;
  localparam int InitClr = 4;

  logic            clk = 1'b0;
  logic            rst_n, en;
  logic [CntW-1:0] g_time, y_time, r_time;
  logic [8:0]      lamps;
  logic [1:0]      active_dir;
  logic            phase_g, phase_y, phase_r, phase_end;
  logic [CntW-1:0] timer;
`ifdef TRAFFIC_PREEMPT_EN
  logic            preempt_req, preempt_active;
  logic [1:0]      preempt_dir;
`endif

  traffic_ctrl_n #(.NUM_DIR(NumDir), .CNT_W(CntW), .INIT_CLR(InitClr)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .g_time(g_time), .y_time(y_time), .r_time(r_time),
`ifdef TRAFFIC_PREEMPT_EN
    .preempt_req(preempt_req), .preempt_dir(preempt_dir), .preempt_active(preempt_active),
`endif
    .lamps(lamps), .active_dir(active_dir),
    .phase_g(phase_g), .phase_y(phase_y), .phase_r(phase_r),
    .phase_end(phase_end), .timer(timer)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: counts elapsed enabled cycles in the current phase.
  typedef enum int {MGreen, MYellow, MRed} mphase_e;
  mphase_e m_ph;
  int m_dir, m_len, m_elapsed;
  int cur_g, cur_y, cur_r, cur_preq, cur_pdir;
  logic [63:0] exp_q[$];
  int gc_q[$];
  int gd_q[$];
  int cyc;
  logic prev_g;
  logic [2:0] prev_st;

  function automatic int dur(input int x);
    return (x == 0) ? 1 : x;
  endfunction

  function automatic logic pre_act();
    return (cur_preq != 0) && (cur_pdir < NumDir);
  endfunction

  function automatic logic [63:0] model_word(input logic en_v);
    logic [8:0] l;
    logic pe;
    l = 9'b001_001_001;
    if (m_ph == MGreen)  l[3*m_dir +: 3] = 3'b100;
    if (m_ph == MYellow) l[3*m_dir +: 3] = 3'b010;
    if (m_ph == MGreen && pre_act()) pe = en_v && (m_dir != cur_pdir);
    else                             pe = en_v && (m_elapsed == m_len - 1);
    return {33'b0, l, 2'(m_dir), m_ph == MGreen, m_ph == MYellow, m_ph == MRed, pe,
            16'(m_len - 1 - m_elapsed)};
  endfunction

  task automatic m_reset();
    m_ph = MRed; m_dir = NumDir - 1; m_len = InitClr; m_elapsed = 0;
    prev_g = 1'b0; prev_st = 3'b001;
  endtask

  task automatic m_step(input logic en_v);
    logic adv;
    if (!en_v) return;
    if (m_ph == MGreen && pre_act() && m_dir == cur_pdir) return;
    adv = (m_ph == MGreen && pre_act()) || (m_elapsed == m_len - 1);
    if (!adv) begin
      m_elapsed++;
      return;
    end
    m_elapsed = 0;
    case (m_ph)
      MGreen:  begin m_ph = MYellow; m_len = dur(cur_y); end
      MYellow: begin m_ph = MRed;    m_len = dur(cur_r); end
      default: begin
        m_ph  = MGreen;
        m_len = dur(cur_g);
        m_dir = pre_act() ? cur_pdir : (m_dir + 1) % NumDir;
      end
    endcase
  endtask

  // One clock: drive at negedge, push expectation, sample, pop and compare.
  task automatic tick(input logic en_v);
    logic [2:0] st;
    int nonred;
    @(negedge clk);
    en = en_v;
    g_time = 16'(cur_g); y_time = 16'(cur_y); r_time = 16'(cur_r);
`ifdef TRAFFIC_PREEMPT_EN
    preempt_req = (cur_preq != 0); preempt_dir = 2'(cur_pdir);
`endif
    exp_q.push_back(model_word(en_v));
    #1;
    check("outs", {33'b0, lamps, active_dir, phase_g, phase_y, phase_r, phase_end, timer},
          exp_q.pop_front());
`ifdef TRAFFIC_PREEMPT_EN
    check("preempt_active", preempt_active, pre_act());
`endif
    nonred = 0;
    for (int d = 0; d < NumDir; d++) if (lamps[3*d +: 3] != 3'b001) nonred++;
    check("one_nonred", nonred <= 1, 1);
    st = {phase_g, phase_y, phase_r};
    check("order", (st == prev_st) || (prev_st == 3'b100 && st == 3'b010) ||
          (prev_st == 3'b010 && st == 3'b001) || (prev_st == 3'b001 && st == 3'b100), 1);
    prev_st = st;
    if (phase_g && !prev_g) begin
      gc_q.push_back(cyc);
      gd_q.push_back(int'(active_dir));
    end
    prev_g = phase_g;
    cyc++;
    m_step(en_v);
  endtask

  function automatic logic hit(input int mode);
    case (mode)
      0:       return phase_g && timer == 16'd4;
      1:       return phase_y && active_dir == 2'd2;
      default: return phase_g && active_dir == 2'd0 && timer == 16'd5;
    endcase
  endfunction

  task automatic wait_state(input string tag, input int mode);
    int k = 0;
    do begin
      tick(1'b1);
      k++;
    end while (!hit(mode) && k < 400);
    check(tag, hit(mode), 1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_lamps"}, lamps, 9'b001_001_001);
    check({tag, "_dir"}, active_dir, 2'd2);
    check({tag, "_flags"}, {phase_g, phase_y, phase_r, phase_end}, 4'b0010);
    check({tag, "_timer"}, timer, InitClr - 1);
  endtask

  task automatic release_reset();
    m_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc = 0;
    gc_q.delete();
    gd_q.delete();
  endtask

  initial begin
    cur_g = 5; cur_y = 2; cur_r = 1; cur_preq = 0; cur_pdir = 0;
    rst_n = 1'b0; en = 1'b0;
    g_time = 16'd5; y_time = 16'd2; r_time = 16'd1;
`ifdef TRAFFIC_PREEMPT_EN
    preempt_req = 1'b0; preempt_dir = 2'd0;
`endif
    @(posedge clk);
    #1 check_reset_state("reset");
    release_reset();

    // Startup: 4 all-red, then 8-cycle slots per direction, 24-cycle rotation.
    repeat (40) tick(1'b1);
    check("green_cnt", gc_q.size(), 5);
    for (int i = 0; i < 4 && i < gc_q.size(); i++) begin
      check("green_cyc", gc_q[i], 4 + 8 * i);
      check("green_dir", gd_q[i], i % NumDir);
    end

    // Zero durations: every phase is one cycle long.
    cur_g = 0; cur_y = 0; cur_r = 0;
    repeat (20) tick(1'b1);
    for (int i = 0; i < 6; i++) begin
      tick(1'b1);
      check("pend_zero", phase_end, 1);
    end

    // Enable freeze mid-green at timer=3.
    cur_g = 5; cur_y = 2; cur_r = 1;
    wait_state("wait_green4", 0);
    for (int i = 0; i < 7; i++) begin
      tick(1'b0);
      check("freeze_timer", timer, 3);
      check("freeze_g", phase_g, 1);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b1);
      check("resume_g", phase_g, 1);
    end
    tick(1'b1);
    check("resume_y", phase_y, 1);

    // Async reset mid-yellow on direction 2.
    wait_state("wait_y2", 1);
    rst_n = 1'b0;
    #1 check_reset_state("midreset");
    release_reset();
    repeat (10) tick(1'b1);
    check("post_rst_cnt", gc_q.size() >= 1, 1);
    if (gc_q.size() >= 1) begin
      check("post_rst_dir", gd_q[0], 0);
      check("post_rst_cyc", gc_q[0], 4);
    end

`ifdef TRAFFIC_PREEMPT_EN
    cur_preq = 1; cur_pdir = 3;
    repeat (4) tick(1'b1);
    cur_preq = 0;
    cur_g = 8; cur_y = 2; cur_r = 1;
    wait_state("wait_g0t5", 2);
    cur_preq = 1; cur_pdir = 2;
    tick(1'b1);
    check("pre_cut_end", phase_end, 1);
    tick(1'b1);
    check("pre_y", phase_y, 1);
    repeat (3) tick(1'b1);
    check("pre_g2", {phase_g, active_dir}, {1'b1, 2'd2});
    for (int i = 0; i < 10; i++) begin
      tick(1'b1);
      check("pre_hold", timer, 7);
    end
    cur_preq = 0;
    gc_q.delete();
    gd_q.delete();
    repeat (15) tick(1'b1);
    check("pre_resume_cnt", gc_q.size() >= 1, 1);
    if (gc_q.size() >= 1) begin
      check("pre_resume_dir", gd_q[0], 0);
      check("pre_resume_cyc", gc_q[0] - (cyc - 15), 11);
    end
`endif

    // Randomised enable and durations.
    for (int i = 0; i < 10000; i++) begin
      cur_g = $urandom_range(0, 6);
      cur_y = $urandom_range(0, 3);
      cur_r = $urandom_range(0, 3);
      tick(($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_ctrl_n.md
Name: traffic_ctrl_n

Overview:
- Parametrised N-approach traffic-light controller. Successor to the fixed two-street controller.
- Owns its own phase timers, so no external g_end/y_end/r_end pulses are needed.
- Sequences directions round-robin: GREEN -> YELLOW -> ALL_RED clearance -> next direction GREEN.
- Drives per-direction lamp triplets plus phase status flags for the intersection top level.

Parameters:
- NUM_DIR, 2, number of approaches (2..8); DIR_W = $clog2(NUM_DIR) is a localparam.
- CNT_W, 16, width of the phase timer and the duration inputs.
- INIT_CLR, 4, all-red clearance cycles after reset (>=1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  timer/state advance enable; low freezes everything.
- g_time  in  CNT_W  green duration in enabled cycles.
- y_time  in  CNT_W  yellow duration.
- r_time  in  CNT_W  all-red clearance duration.
- lamps  out  3*NUM_DIR  per direction d, bits [3d+2:3d]: 3'b100 green, 3'b010 yellow, 3'b001 red.
- active_dir  out  DIR_W  direction currently owning (or last owning) the right of way.
- phase_g / phase_y / phase_r  out  1  one-hot state flags (GREEN / YELLOW / ALL_RED).
- phase_end  out  1  high in the last enabled cycle of any phase.
- timer  out  CNT_W  current remaining count.

Behaviour:
- Reset (async):
  - state=ALL_RED, active_dir=NUM_DIR-1, timer=INIT_CLR-1.
  - All lamps 3'b001; phase_r=1, phase_g=0, phase_y=0, phase_end=0.
- States: GREEN, YELLOW, ALL_RED. State and timer are registered; all outputs decode combinationally from registers.
- Phase entry:
  - Load timer with D-1, where D = max(duration input, 1). g_time, y_time, r_time are sampled only on the entry cycle.
  - A zero duration gives a 1-cycle phase; mid-phase changes to the inputs have no effect.
- Enabled cycle (en=1):
  - If timer==0: phase_end=1 and the transition is taken at the next clock edge.
  - Otherwise timer decrements.
  - Each phase therefore lasts exactly D enabled cycles.
- Transitions:
  - GREEN -> YELLOW.
  - YELLOW -> ALL_RED.
  - ALL_RED -> GREEN, with active_dir incremented and wrapping NUM_DIR-1 -> 0.
- en=0: state, timer and active_dir hold; phase_end=0.
- Lamps:
  - In GREEN/YELLOW, only active_dir shows 3'b100 or 3'b010; every other direction shows 3'b001.
  - In ALL_RED, all directions show 3'b001.
  - At most one direction is ever non-red.
- Reset asserted mid-phase returns immediately to the reset state; the first green after reset is always direction 0.
- Illegal state encoding recovers to ALL_RED with timer=0 on the next clock.

Optional Feature:
- Macro: TRAFFIC_PREEMPT_EN.
- Defined:
  - Adds ports preempt_req (in, 1, level), preempt_dir (in, DIR_W) and preempt_active (out, 1, = preempt_req with valid preempt_dir).
  - preempt_dir >= NUM_DIR is ignored, i.e. treated as no request.
- While preempt_active:
  - GREEN of a direction != preempt_dir goes to YELLOW at the next edge, regardless of timer.
  - GREEN of preempt_dir holds its timer (green extended).
  - YELLOW and ALL_RED run normally, but ALL_RED -> GREEN loads active_dir = preempt_dir instead of the increment.
- After the request drops:
  - The preempted green finishes its remaining count.
  - Rotation resumes at preempt_dir+1, with wrap.
- Not defined: the ports are absent and behaviour is pure round-robin.

Test Plan:
- Reset/startup: NUM_DIR=3, g=5, y=2, r=1, en=1 after reset -> 4 cycles all-red, dir0 green 5, yellow 2, red 1, then dir1 green; full rotation period 24 cycles; active_dir sequence 0,1,2,0.
- Zero durations: g=0, y=0, r=0 -> each phase lasts 1 cycle; phase_end high every enabled cycle.
- Enable freeze: drop en for 7 cycles mid-green at timer=3 -> timer, lamps and state hold; green completes 4 cycles after en returns.
- Async reset mid-yellow on dir2 -> lamps all 3'b001 immediately; active_dir=2 (NUM_DIR-1); next green is dir0.
- Invariant check, randomized en and durations for 10k cycles -> never more than one non-red triplet; every green followed by yellow then all-red.
- TRAFFIC_PREEMPT_EN: preempt_req=1, preempt_dir=2 during dir0 green at timer=4 -> yellow next cycle, then all-red, then dir2 green held while req; req drop -> remaining count, then dir0 green.
